// File: rtl/even_parity_rx_3bit_pkg.sv
`default_nettype none
// =============================================================================
// Module   : even_parity_pkg
// Brief    : Shared types and constants for the even-parity serial receiver.
// Revision : 1.0  initial release
// =============================================================================
package even_parity_pkg;

    localparam int   DATA_W_DEF = 3;
    localparam int   FRAME_LEN  = DATA_W_DEF + 3;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/even_parity_rx_3bit_if.sv
`default_nettype none
// =============================================================================
// Module   : even_parity_rx_3bit_if
// Brief    : Serial line in, received word and status out.
// Revision : 1.0  initial release
// =============================================================================
interface even_parity_rx_3bit_if
    import even_parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ERR_W  = 8
);
    logic              en;
    logic              sin;
    logic [DATA_W-1:0] i;
    logic              p;
    logic              valid;
    logic              p_err;
    logic              f_err;
    logic              busy;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        output en, sin,
        input  i, p, valid, p_err, f_err, busy, err_cnt
    );

    modport slave (
        input  en, sin,
        output i, p, valid, p_err, f_err, busy, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/even_p_gen_3bit.sv
`default_nettype none
// =============================================================================
// Module   : even_p_gen_3bit
// Brief    : 3-bit even parity generator (parity bit makes total ones even).
// Revision : 1.0  initial release
// =============================================================================
module even_p_gen_3bit (
    input  wire logic [2:0] data,
    output logic            parity
);
    assign parity = ^data;
endmodule
`default_nettype wire

// File: rtl/even_parity_rx_3bit.sv
`default_nettype none
// =============================================================================
// Module   : even_parity_rx_3bit
// Brief    : Even-parity serial frame receiver with saturating error counter.
// Revision : 1.0  initial release
// =============================================================================
module even_parity_rx_3bit
    import even_parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ERR_W  = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    even_parity_rx_3bit_if.slave  bus
);
    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_par;
    logic              r_pbit;
    logic              r_perr;
    logic [DATA_W-1:0] r_i;
    logic              r_p;
    logic              r_valid;
    logic              r_p_err;
    logic              r_f_err;
    logic [ERR_W-1:0]  r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (bus.en) begin
            case (r_state)
                IDLE:    if (bus.sin != IDLE_LEVEL) w_next = DATA;
                DATA:    if (r_cnt == LAST_BIT) w_next = PARITY;
                PARITY:  w_next = STOP;
                STOP:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_cnt     <= '0;
            r_par     <= 1'b0;
            r_pbit    <= 1'b0;
            r_perr    <= 1'b0;
            r_i       <= '0;
            r_p       <= 1'b0;
            r_valid   <= 1'b0;
            r_p_err   <= 1'b0;
            r_f_err   <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_valid <= 1'b0;
            if (bus.en) begin
                case (r_state)
                    IDLE: begin
                        if (bus.sin != IDLE_LEVEL) begin
                            r_cnt <= '0;
                            r_par <= 1'b0;
                        end
                    end
                    DATA: begin
                        r_shift[r_cnt] <= bus.sin;
                        r_par          <= r_par ^ bus.sin;
                        r_cnt          <= r_cnt + CNT_W'(1);
                    end
                    PARITY: begin
                        r_pbit <= bus.sin;
                        r_perr <= r_par ^ bus.sin;
                    end
                    STOP: begin
                        r_i     <= r_shift;
                        r_p     <= r_pbit;
                        r_p_err <= r_perr;
                        r_f_err <= ~bus.sin;
                        r_valid <= 1'b1;
                        // One count per bad frame, however many error kinds it has
                        if ((r_perr || !bus.sin) && (r_err_cnt != ERR_MAX)) begin
                            r_err_cnt <= r_err_cnt + ERR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.i       = r_i;
    assign bus.p       = r_p;
    assign bus.valid   = r_valid;
    assign bus.p_err   = r_p_err;
    assign bus.f_err   = r_f_err;
    assign bus.busy    = (r_state != IDLE);
    assign bus.err_cnt = r_err_cnt;

    generate
        if (DATA_W == 3) begin : g_xcheck
            logic w_gen_par;

            even_p_gen_3bit u_gen (
                .data   (r_shift),
                .parity (w_gen_par)
            );

            // Once all data bits are in, the running XOR must equal the word's parity
            always_ff @(posedge clk) begin
                if (!rst && (r_state == PARITY)) begin
                    assert (w_gen_par == r_par);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_even_parity_rx_3bit.sv
`default_nettype none
// =============================================================================
// Module   : tb_even_parity_rx_3bit
// Brief    : Self-checking bench: frame-level reference model, directed + random.
// Revision : 1.0  initial release
// =============================================================================
module tb_even_parity_rx_3bit;
    import even_parity_pkg::*;

    localparam int DW = 3;

    logic clk = 1'b0;
    logic rst;
    logic en_d;
    logic sin_d;
    logic cmp_on;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    even_parity_rx_3bit_if #(.DATA_W(DW), .ERR_W(8)) bus8 ();
    even_parity_rx_3bit_if #(.DATA_W(DW), .ERR_W(2)) bus2 ();

    assign bus8.en  = en_d;
    assign bus8.sin = sin_d;
    assign bus2.en  = en_d;
    assign bus2.sin = sin_d;

    even_parity_rx_3bit #(.DATA_W(DW), .ERR_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    even_parity_rx_3bit #(.DATA_W(DW), .ERR_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Frame-level model: collect the bits after a start bit, then judge the frame
    int m_in_frame;
    int m_nbits;
    int m_bits[DW+2];
    int m_i, m_p, m_perr, m_ferr, m_valid, m_errs;

    always @(posedge clk) begin
        if (rst) begin
            m_in_frame = 0; m_nbits = 0;
            m_i = 0; m_p = 0; m_perr = 0; m_ferr = 0; m_valid = 0; m_errs = 0;
        end else begin
            m_valid = 0;
            if (en_d) begin
                if (m_in_frame == 0) begin
                    if (sin_d == 1'b0) begin
                        m_in_frame = 1;
                        m_nbits    = 0;
                    end
                end else begin
                    m_bits[m_nbits] = int'(sin_d);
                    m_nbits++;
                    if (m_nbits == DW + 2) begin
                        int data, ones;
                        data = 0; ones = 0;
                        for (int k = 0; k < DW; k++) begin
                            data += m_bits[k] * (1 << k);
                            ones += m_bits[k];
                        end
                        m_i        = data;
                        m_p        = m_bits[DW];
                        m_perr     = (ones + m_bits[DW]) % 2;
                        m_ferr     = (m_bits[DW+1] == 0) ? 1 : 0;
                        if (m_perr != 0 || m_ferr != 0) m_errs++;
                        m_valid    = 1;
                        m_in_frame = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("valid",    int'(bus8.valid),   m_valid);
            chk("busy",     int'(bus8.busy),    m_in_frame);
            chk("i",        int'(bus8.i),       m_i);
            chk("p",        int'(bus8.p),       m_p);
            chk("p_err",    int'(bus8.p_err),   m_perr);
            chk("f_err",    int'(bus8.f_err),   m_ferr);
            chk("err_cnt8", int'(bus8.err_cnt), sat(m_errs, 255));
            chk("valid2",   int'(bus2.valid),   m_valid);
            chk("i2",       int'(bus2.i),       m_i);
            chk("err_cnt2", int'(bus2.err_cnt), sat(m_errs, 3));
        end
    end

    task automatic drive(input logic r, input logic e, input logic s);
        rst   = r;
        en_d  = e;
        sin_d = s;
        @(posedge clk);
        #1;
    endtask

    // v[k] is the k-th serial bit: start, data LSB first, parity, stop
    task automatic send_frame(input logic [FRAME_LEN-1:0] v, input int gap);
        for (int k = 0; k < FRAME_LEN; k++) begin
            repeat (gap) drive(1'b0, 1'b0, 1'($urandom % 2));
            drive(1'b0, 1'b1, v[k]);
        end
    endtask

    task automatic expect_frame(input string tag, input int ei, input int ep,
                                input int epe, input int efe, input int ec8, input int ec2);
        chk({tag, ".valid"},   int'(bus8.valid),   1);
        chk({tag, ".i"},       int'(bus8.i),       ei);
        chk({tag, ".p"},       int'(bus8.p),       ep);
        chk({tag, ".p_err"},   int'(bus8.p_err),   epe);
        chk({tag, ".f_err"},   int'(bus8.f_err),   efe);
        chk({tag, ".err_cnt"}, int'(bus8.err_cnt), ec8);
        chk({tag, ".err_cnt2"},int'(bus2.err_cnt), ec2);
    endtask

    initial begin
        cmp_on = 1'b0;
        rst = 1'b1; en_d = 1'b0; sin_d = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        chk("rst.valid",   int'(bus8.valid),   0);
        chk("rst.busy",    int'(bus8.busy),    0);
        chk("rst.i",       int'(bus8.i),       0);
        chk("rst.err_cnt", int'(bus8.err_cnt), 0);
        cmp_on = 1'b1;

        // Clean frame, then back-to-back parity and framing errors
        send_frame(6'b101010, 0);
        expect_frame("clean", 5, 0, 0, 0, 0, 0);
        send_frame(6'b110110, 0);
        expect_frame("perr", 3, 1, 1, 0, 1, 1);
        send_frame(6'b011000, 0);
        expect_frame("ferr", 4, 1, 0, 1, 2, 2);
        chk("ferr.busy_after_stop", int'(bus8.busy), 0);

        // Line held low after a break: idle on en=0, start on next sampled en cycle
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("break.no_start", int'(bus8.busy), 0);
        drive(1'b0, 1'b1, 1'b0);
        chk("break.rearm", int'(bus8.busy), 1);
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 1'b1);
        expect_frame("rearm", 7, 1, 0, 0, 2, 2);

        // Gapped strobe: en once every 4 cycles
        send_frame(6'b111110, 3);
        expect_frame("gapped", 7, 1, 0, 0, 2, 2);
        drive(1'b0, 1'b0, 1'b1);
        chk("gapped.valid_1clk", int'(bus8.valid), 0);

        // Reset after the second data bit aborts the frame
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        chk("abort.busy",    int'(bus8.busy),    0);
        chk("abort.valid",   int'(bus8.valid),   0);
        chk("abort.err_cnt", int'(bus8.err_cnt), 0);
        drive(1'b0, 1'b1, 1'b1);
        chk("abort.valid_after", int'(bus8.valid), 0);
        send_frame(6'b110100, 0);
        expect_frame("after_abort", 2, 1, 0, 0, 0, 0);

        // Counter saturation on the narrow instance
        for (int n = 1; n <= 5; n++) begin
            send_frame(6'b110110, 0);
            expect_frame("sat", 3, 1, 1, 0, n, sat(n, 3));
        end

        // Random line activity, strobe pattern and occasional resets
        for (int c = 0; c < 4000; c++) begin
            drive(1'($urandom_range(0, 299) == 0),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 3) != 0));
        end
        drive(1'b0, 1'b0, 1'b1);

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
